// File: rtl/gf2_pp_accumulator_if.sv
// ---------------------------------------------------------------------------
// gf2_pp_accumulator_if
//
// Purpose: bundles the two streams of the GF(2) partial-product accumulator.
//   Upstream pp_* stream: digit partial products from the Karatsuba multiplier.
//   Downstream res_* stream: finished wide product to the reduction stage.
//
// Handshake (both streams): a beat transfers on a rising clock edge where
// valid && ready are both high. The producer holds valid and its payload
// stable until that edge. ready may be high with valid low; nothing moves.
//
// Signals:
//   pp_valid  (master->slave)  partial product presented
//   pp_ready  (slave->master)  accumulator can take a partial product
//   pp_data   (master->slave)  2N-1 bit carry-less partial product, bit0 = x^0
//   pp_shift  (master->slave)  digit offset s = i+j, placed at bit s*N
//   pp_last   (master->slave)  final partial product of this multiplication
//   res_valid (slave->master)  res_data holds a complete product
//   res_ready (master->slave)  downstream takes the product
//   res_data  (slave->master)  AW-bit accumulated product, bit0 = x^0
//   err       (slave->master)  sticky partial-product count error
//
// Modports:
//   slave  - the accumulator's view
//   master - the environment's view (multiplier upstream + reduction downstream)
// ---------------------------------------------------------------------------
interface gf2_pp_accumulator_if #(
  parameter int N  = 36,
  parameter int K  = 8,
  parameter int SW = 4
);
  localparam int PW = 2 * N - 1;
  localparam int AW = 2 * N * K - 1;

  logic          pp_valid;
  logic          pp_ready;
  logic [PW-1:0] pp_data;
  logic [SW-1:0] pp_shift;
  logic          pp_last;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_data;
  logic          err;

  modport slave (
    input  pp_valid, pp_data, pp_shift, pp_last, res_ready,
    output pp_ready, res_valid, res_data, err
  );

  modport master (
    output pp_valid, pp_data, pp_shift, pp_last, res_ready,
    input  pp_ready, res_valid, res_data, err
  );
endinterface

// File: rtl/gf2_pp_accumulator.sv
// ---------------------------------------------------------------------------
// gf2_pp_accumulator
//
// Purpose: post-multiplier stage. Takes a stream of (2N-1)-bit carry-less
// digit partial products, each tagged with a digit offset s, shifts each to
// bit s*N and XOR-accumulates it into an AW = 2*N*K-1 bit product register.
// When the partial product flagged pp_last is taken, the full polynomial
// product is offered downstream and held until res_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   bus          gf2_pp_accumulator_if.slave (pp_* in, res_* out, err)
//   dbg_state_o  current FSM state (0 IDLE, 1 ACC, 2 DONE)
//
// Optional feature, macro GF2_PP_COUNT_CHECK_EN:
//   defined   - transfers per multiplication are counted; a pp_last transfer
//               whose running total differs from K*K sets err (sticky until
//               rst). The product is still delivered unchanged.
//   undefined - no counter is built and err is tied low.
// ---------------------------------------------------------------------------
module gf2_pp_accumulator #(
  parameter int N  = 36,
  parameter int K  = 8,
  parameter int SW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gf2_pp_accumulator_if.slave    bus,
  output logic [1:0]             dbg_state_o
);

  localparam int AW        = 2 * N * K - 1;
  localparam int MAX_SHIFT = 2 * K - 2;
  // Wide enough for the largest encodable offset times N.
  localparam int SHW       = $clog2(((1 << SW) - 1) * N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] acc_q;
  logic          pp_ready_q;
  logic          res_valid_q;

  logic [SHW-1:0] shamt;
  logic [AW-1:0]  term;
  logic [AW-1:0]  acc_d;
  logic           xfer;

  // Place the partial product at its digit offset. Offsets beyond the
  // highest legal digit pair contribute nothing but still count as a beat.
  always_comb begin
    shamt = SHW'(bus.pp_shift) * SHW'(N);
    term  = '0;
    if (bus.pp_shift <= SW'(MAX_SHIFT)) begin
      term = AW'(bus.pp_data) << shamt;
    end
  end

  assign xfer = bus.pp_valid && pp_ready_q;

  // First beat of a multiplication overwrites the register, so the previous
  // product never needs an explicit clear on leaving DONE.
  always_comb begin
    acc_d = acc_q ^ term;
    if (state_q == IDLE) begin
      acc_d = term;
    end
  end

`ifdef GF2_PP_COUNT_CHECK_EN
  // One spare bit above K*K so the saturated value can never alias K*K.
  localparam int CW = $clog2(K * K + 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = CW'(1);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pp_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
`ifdef GF2_PP_COUNT_CHECK_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (xfer) begin
            acc_q <= acc_d;
`ifdef GF2_PP_COUNT_CHECK_EN
            cnt_q <= cnt_d;
`endif
            if (bus.pp_last) begin
              state_q     <= DONE;
              pp_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
`ifdef GF2_PP_COUNT_CHECK_EN
              if (cnt_d != CW'(K * K)) begin
                err_q <= 1'b1;
              end
`endif
            end else begin
              state_q <= ACC;
            end
          end
        end

        DONE: begin
          if (res_valid_q && bus.res_ready) begin
            state_q     <= IDLE;
            pp_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          pp_ready_q  <= 1'b1;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pp_ready  = pp_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = acc_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_gf2_pp_accumulator.sv
module tb_gf2_pp_accumulator;

  localparam int N  = 36;
  localparam int K  = 8;
  localparam int SW = 4;
  localparam int PW = 2 * N - 1;
  localparam int AW = 2 * N * K - 1;
  localparam int OW = N * K;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  gf2_pp_accumulator_if #(.N(N), .K(K), .SW(SW)) bus ();

  gf2_pp_accumulator #(.N(N), .K(K), .SW(SW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [AW-1:0] exp_q[$];
  bit            err_model;
  bit            in_product;
  int            xfer_cnt;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference math ----------------
  function automatic logic [PW-1:0] clmul_digit(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (y[i]) r ^= PW'(x) << i;
    return r;
  endfunction

  function automatic logic [AW-1:0] clmul_full(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < OW; i++) if (b[i]) r ^= AW'(a) << i;
    return r;
  endfunction

  task automatic rand_op(input bit top_digit_zero, output logic [OW-1:0] v);
    v = '0;
    for (int w = 0; w < OW / 32; w++) v[w*32 +: 32] = $urandom();
    v[OW-1:283] = '0;
    if (top_digit_zero) v[OW-1:(K-1)*N] = '0;
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset(input int cycles);
    rst           = 1'b1;
    bus.pp_valid  = 1'b0;
    bus.pp_data   = '0;
    bus.pp_shift  = '0;
    bus.pp_last   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst        = 1'b0;
    err_model  = 1'b0;
    in_product = 1'b0;
    xfer_cnt   = 0;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the beat was taken.
  task automatic send_pp(input logic [PW-1:0] d, input logic [SW-1:0] s, input logic last);
    int waited;
    waited       = 0;
    bus.pp_valid = 1'b1;
    bus.pp_data  = d;
    bus.pp_shift = s;
    bus.pp_last  = last;
    while (!bus.pp_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.pp_ready) begin
      check("pp_ready_timeout", AW'(bus.pp_ready), AW'(1'b1));
    end else begin
      @(negedge clk);
      if (!in_product) xfer_cnt = 0;
      in_product = 1'b1;
      xfer_cnt++;
      if (last) begin
        in_product = 1'b0;
`ifdef GF2_PP_COUNT_CHECK_EN
        if (xfer_cnt != K * K) err_model = 1'b1;
`endif
      end
    end
    bus.pp_valid = 1'b0;
    bus.pp_last  = 1'b0;
  endtask

  // Sends the digit products of a*b; optionally omits the (K-1,K-1) term and
  // optionally stops (without pp_last) after `limit` beats.
  task automatic send_full(input logic [OW-1:0] a, input logic [OW-1:0] b,
                           input bit skip_top, input int limit);
    int  sent;
    bit  last;
    sent = 0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        if (sent >= limit) return;
        if (!(skip_top && i == K - 1 && j == K - 1)) begin
          last = skip_top ? (i == K - 1 && j == K - 2) : (i == K - 1 && j == K - 1);
          send_pp(clmul_digit(a[i*N +: N], b[j*N +: N]), SW'(i + j), last);
          sent++;
        end
      end
    end
  endtask

  // Waits for a result, optionally stalls it, then accepts and compares.
  task automatic recv_res(input int stall);
    int            waited;
    logic [AW-1:0] exp;
    waited = 0;
    while (!bus.res_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.res_valid) begin
      check("res_valid_timeout", AW'(bus.res_valid), AW'(1'b1));
      return;
    end
    if (exp_q.size() == 0) begin
      check("exp_q_size", AW'(exp_q.size()), AW'(1));
      return;
    end
    exp = exp_q.pop_front();
    for (int c = 0; c < stall; c++) begin
      // Junk beats while the product is held must be ignored.
      bus.pp_valid = c[0];
      bus.pp_data  = '1;
      bus.pp_shift = '0;
      bus.pp_last  = 1'b1;
      @(negedge clk);
      check("stall_res_valid", AW'(bus.res_valid), AW'(1'b1));
      check("stall_res_data", bus.res_data, exp);
      check("stall_pp_ready", AW'(bus.pp_ready), AW'(1'b0));
    end
    bus.pp_valid = 1'b0;
    bus.pp_last  = 1'b0;
    check("res_data", bus.res_data, exp);
    check("err", AW'(bus.err), AW'(err_model));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("post_res_valid", AW'(bus.res_valid), AW'(1'b0));
    check("post_pp_ready", AW'(bus.pp_ready), AW'(1'b1));
    check("post_state", AW'(dbg_state), AW'(ST_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [AW-1:0] e;
    logic [OW-1:0] a, b;
    logic [PW-1:0] ones;

    ones = '1;
    do_reset(3);
    check("reset_res_valid", AW'(bus.res_valid), AW'(1'b0));
    check("reset_pp_ready", AW'(bus.pp_ready), AW'(1'b1));
    check("reset_err", AW'(bus.err), AW'(1'b0));
    check("reset_state", AW'(dbg_state), AW'(ST_IDLE));

    // Single beat, one-cycle latency.
    send_pp(PW'(3), 4'd0, 1'b1);
    check("single_res_valid", AW'(bus.res_valid), AW'(1'b1));
    check("single_pp_ready", AW'(bus.pp_ready), AW'(1'b0));
    check("single_state", AW'(dbg_state), AW'(ST_DONE));
    exp_q.push_back(AW'(3));
    recv_res(0);

    // Overlapping digits: bits 70 and 36 both set.
    send_pp(PW'(1) << 70, 4'd0, 1'b0);
    send_pp(PW'(1), 4'd1, 1'b1);
    e = '0; e[70] = 1'b1; e[36] = 1'b1;
    exp_q.push_back(e);
    recv_res(0);

    // Bit 36 from two beats cancels.
    send_pp(PW'(1) << 70, 4'd0, 1'b0);
    send_pp(PW'(1), 4'd1, 1'b0);
    send_pp(PW'(1) << 36, 4'd0, 1'b1);
    e = '0; e[70] = 1'b1;
    exp_q.push_back(e);
    recv_res(0);

    // Backpressure, then the next product must overwrite the held value.
    send_pp(PW'(12'habc), 4'd2, 1'b1);
    exp_q.push_back(AW'(12'habc) << 72);
    recv_res(5);
    send_pp(PW'(5), 4'd0, 1'b1);
    exp_q.push_back(AW'(5));
    recv_res(0);

    // Out-of-range offset contributes nothing.
    send_pp(ones, 4'd15, 1'b0);
    send_pp(PW'(1), 4'd0, 1'b1);
    exp_q.push_back(AW'(1));
    recv_res(0);

    // Highest offset fills bits 504..574.
    send_pp(ones, 4'd14, 1'b1);
    e = '0;
    for (int i = 504; i < AW; i++) e[i] = 1'b1;
    exp_q.push_back(e);
    recv_res(1);

    // Reset while a product is waiting in DONE.
    send_pp(PW'(7), 4'd0, 1'b1);
    do_reset(1);
    check("rst_done_res_valid", AW'(bus.res_valid), AW'(1'b0));
    check("rst_done_state", AW'(dbg_state), AW'(ST_IDLE));

    // Reset mid-accumulation after 10 of 64 beats.
    rand_op(1'b0, a);
    rand_op(1'b0, b);
    send_full(a, b, 1'b0, 10);
    do_reset(1);
    check("rst_mid_res_valid", AW'(bus.res_valid), AW'(1'b0));
    check("rst_mid_state", AW'(dbg_state), AW'(ST_IDLE));
    check("rst_mid_err", AW'(bus.err), AW'(1'b0));

    // Full products with no residue from the aborted one.
    for (int t = 0; t < 2; t++) begin
      rand_op(1'b0, a);
      rand_op(1'b0, b);
      exp_q.push_back(clmul_full(a, b));
      send_full(a, b, 1'b0, K * K);
      recv_res(t);
    end

    // 63 beats: top digit of a is zero so the omitted term is zero and the
    // product is still the full one; the count check flags it.
    rand_op(1'b1, a);
    rand_op(1'b0, b);
    exp_q.push_back(clmul_full(a, b));
    send_full(a, b, 1'b1, K * K);
    recv_res(0);
    check("err_sticky", AW'(bus.err), AW'(err_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
